mod_seq_counter: RTL

Parametrised modulo counter that generalises the team's fixed 3-bit DFF sequence counter. It provides:

- configurable width and modulus;
- up/down direction and binary/Gray output encoding;
- synchronous load;
- wrap or saturate behaviour at the terminal count.

It sits wherever a sequencer, divider or address generator needs a registered count with true/complement outputs and terminal-count flags.

---
 rtl/mod_seq_counter.sv | 88 ++++++++
 1 files changed

// File: rtl/mod_seq_counter.sv
// rtl/mod_seq_counter.sv - parametrised modulo counter with up/down, binary/Gray output,
// synchronous load and wrap/saturate at the terminal count.
module mod_seq_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             roll
);
    localparam int               LAST_I = MODULUS - 1;
    localparam logic [WIDTH-1:0] LAST   = LAST_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic             SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qb;
    logic             r_tc;
    logic             r_roll;

    logic [WIDTH-1:0] w_next_idx;
    logic [WIDTH-1:0] w_code;
    logic             w_roll;
    logic             w_tc;
    logic             w_down;
    logic             w_gray;

    assign w_down = mode[0];
    assign w_gray = mode[1];

    // Terminal steps never form idx+1 or idx-1, so the index cannot leave 0..MODULUS-1.
    always_comb begin
        w_next_idx = r_idx;
        w_roll     = 1'b0;
        if (load) begin
            w_next_idx = (din > LAST) ? LAST : din;
        end else if (en) begin
            if (!w_down) begin
                if (r_idx == LAST) begin
                    w_roll     = 1'b1;
                    w_next_idx = SAT ? LAST : '0;
                end else begin
                    w_next_idx = r_idx + ONE;
                end
            end else begin
                if (r_idx == '0) begin
                    w_roll     = 1'b1;
                    w_next_idx = SAT ? '0 : LAST;
                end else begin
                    w_next_idx = r_idx - ONE;
                end
            end
        end
    end

    assign w_code = w_gray ? (w_next_idx ^ (w_next_idx >> 1)) : w_next_idx;
    assign w_tc   = w_down ? (w_next_idx == '0) : (w_next_idx == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_q    <= '0;
            r_qb   <= '1;
            r_tc   <= 1'b0;
            r_roll <= 1'b0;
        end else begin
            r_idx  <= w_next_idx;
            r_q    <= w_code;
            r_qb   <= ~w_code;
            r_tc   <= w_tc;
            r_roll <= w_roll;
        end
    end

    assign q    = r_q;
    assign qb   = r_qb;
    assign tc   = r_tc;
    assign roll = r_roll;
endmodule
